// File: rtl/fetch_unit_pkg.sv
// Shared types, opcode constants and FSM encoding for the fetch stage.
package fetch_unit_pkg;

    typedef logic [31:0] instr_t;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] imm_t;

    // One instruction-FIFO entry: 32 + 32 + 1 + 1 + 32 = 98 bits.
    typedef struct packed {
        instr_t instr;
        addr_t  pc;
        logic   is_cond_br;
        logic   br_dir_pred;
        addr_t  br_target_pred;
    } ififo_entry_t;

    localparam logic [6:0] BR_OPCODE   = 7'b1100011;
    localparam logic [6:0] JAL_OPCODE  = 7'b1101111;
    localparam logic [6:0] JALR_OPCODE = 7'b1100111;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    // Non-branches carry target = pc+4 with direction 0, so this one rule
    // yields the correct next PC for every predecoded entry.
    function automatic addr_t entry_next_pc(ififo_entry_t e);
        return e.br_dir_pred ? e.br_target_pred : (e.pc + 32'd4);
    endfunction

endpackage

// File: rtl/fetch_unit_bht.sv
// Bimodal branch history table: 2-bit saturating counters, one async read
// port and one synchronous update port. A read in the update cycle sees the
// pre-update counter because the read is taken straight off the registers.
module fetch_unit_bht #(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_ctr_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam int NUM_ENTRIES = 1 << IDX_W;

    logic [1:0] ctr_q [NUM_ENTRIES];
    logic [1:0] cur_ctr;
    logic [1:0] upd_ctr_d;

    assign rd_ctr_o = ctr_q[rd_idx_i];
    assign cur_ctr  = ctr_q[wr_idx_i];

    // Saturating increment/decrement of the addressed counter.
    always_comb begin
        upd_ctr_d = cur_ctr;
        if (wr_taken_i) begin
            if (cur_ctr != 2'b11) upd_ctr_d = cur_ctr + 2'b01;
        end else begin
            if (cur_ctr != 2'b00) upd_ctr_d = cur_ctr - 2'b01;
        end
    end

    // Counter storage; reset leaves every entry weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= upd_ctr_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, keeps one I-cache request in flight,
// predecodes/predicts each returned word and pushes it into the IFIFO.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BHT_IDX_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    output logic         icache_req_valid,
    input  logic         icache_req_ready,
    output logic [31:0]  icache_req_addr,
    input  logic         icache_resp_valid,
    input  logic [31:0]  icache_resp_instr,
    output logic         ififo_enq_valid,
    input  logic         ififo_enq_ready,
    output ififo_entry_t ififo_enq_data,
    input  logic         recover_valid,
    input  logic [31:0]  recover_pc,
    input  logic         bht_upd_valid,
    input  logic [31:0]  bht_upd_pc,
    input  logic         bht_upd_taken
);

    fetch_state_e state_q;
    addr_t        pc_q;
    ififo_entry_t hold_q;

    ififo_entry_t pred_entry;
    logic [1:0]   bht_rd_ctr;
    logic [6:0]   opcode;
    imm_t         b_imm;
    imm_t         j_imm;
    addr_t        recover_pc_aligned;
    logic         unused_bits;

    assign recover_pc_aligned = {recover_pc[31:2], 2'b00};

    fetch_unit_bht #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (pc_q[BHT_IDX_W+1:2]),
        .rd_ctr_o   (bht_rd_ctr),
        .wr_en_i    (bht_upd_valid),
        .wr_idx_i   (bht_upd_pc[BHT_IDX_W+1:2]),
        .wr_taken_i (bht_upd_taken)
    );

    // Only the counter MSB and the index bits of the PCs are meaningful.
    assign unused_bits = ^{bht_upd_pc[31:BHT_IDX_W+2], bht_upd_pc[1:0],
                           recover_pc[1:0], bht_rd_ctr[0]};

    // Immediate extraction and direction/target prediction for the response.
    always_comb begin
        opcode = icache_resp_instr[6:0];
        b_imm  = {{19{icache_resp_instr[31]}}, icache_resp_instr[31],
                  icache_resp_instr[7], icache_resp_instr[30:25],
                  icache_resp_instr[11:8], 1'b0};
        j_imm  = {{11{icache_resp_instr[31]}}, icache_resp_instr[31],
                  icache_resp_instr[19:12], icache_resp_instr[20],
                  icache_resp_instr[30:21], 1'b0};

        pred_entry.instr          = icache_resp_instr;
        pred_entry.pc             = pc_q;
        pred_entry.is_cond_br     = 1'b0;
        pred_entry.br_dir_pred    = 1'b0;
        pred_entry.br_target_pred = pc_q + 32'd4;

        if (opcode == BR_OPCODE) begin
            pred_entry.is_cond_br     = 1'b1;
            pred_entry.br_dir_pred    = bht_rd_ctr[1];
            pred_entry.br_target_pred = pc_q + b_imm;
        end else if (opcode == JAL_OPCODE) begin
            pred_entry.br_dir_pred    = 1'b1;
            pred_entry.br_target_pred = pc_q + j_imm;
        end
    end

    // Handshake outputs decoded from state; the WAIT push is zero-latency.
    always_comb begin
        icache_req_valid = !rst && (state_q == S_REQ);
        icache_req_addr  = pc_q;
        ififo_enq_valid  = !rst && ((state_q == S_HOLD) ||
                           ((state_q == S_WAIT) && icache_resp_valid && !recover_valid));
        ififo_enq_data   = (state_q == S_HOLD) ? hold_q : pred_entry;
    end

    // Fetch FSM; a redirect overrides every other event in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (recover_valid) begin
                        pc_q    <= recover_pc_aligned;
                        state_q <= icache_req_ready ? S_DROP : S_REQ;
                    end else if (icache_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (recover_valid) begin
                        pc_q    <= recover_pc_aligned;
                        state_q <= icache_resp_valid ? S_REQ : S_DROP;
                    end else if (icache_resp_valid) begin
                        if (ififo_enq_ready) begin
                            pc_q    <= entry_next_pc(pred_entry);
                            state_q <= S_REQ;
                        end else begin
                            hold_q  <= pred_entry;
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (recover_valid) begin
                        pc_q    <= recover_pc_aligned;
                        state_q <= S_REQ;
                    end else if (ififo_enq_ready) begin
                        pc_q    <= entry_next_pc(hold_q);
                        state_q <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (recover_valid) pc_q <= recover_pc_aligned;
                    if (icache_resp_valid) state_q <= S_REQ;
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

endmodule
